alu_sequencer: RTL
==================

Name: alu_sequencer

Overview:
Sequences the picoMips accumulator ALU. It accepts one macro-instruction at a time over a valid/ready handshake. It drives the ALU control lines (WE, SelSW, SelImm, SelRegData, UseMul, UseACC) for one or more cycles, including multi-cycle ops: multiply-then-add, repeated multiply (power) and wait-for-switch load. It sits between instruction decode and the ALU. The ALU's Imm and RegData inputs are supplied by upstream and held stable while Busy.

Parameters:
RPT_W, 3, width of the repeat-count field for POW
OP_W, 4, opcode width

Ports:
Clock  input  1  system clock, rising edge
nReset  input  1  asynchronous active-low reset
InstrValid  input  1  upstream has an instruction
InstrReady  output  1  sequencer can accept; high only in IDLE
Op  input  OP_W  macro opcode, sampled on accept
Rpt  input  RPT_W  repeat count for POW, sampled on accept
SwStrobe  input  1  switch value valid, used by LDS
WE  output  1  ALU accumulator write enable
SelSW  output  1  select switches as the ALU operand
SelImm  output  1  select immediate as the ALU operand
SelRegData  output  1  select register data as the ALU operand
UseMul  output  1  ALU multiplies by Imm
UseACC  output  1  ALU adds the ACC term
Busy  output  1  instruction in progress (state != IDLE)
Done  output  1  one-cycle pulse in the cycle of the final WE (or the final cycle for no-write ops)
IllegalOp  output  1  one-cycle pulse when an undefined opcode is accepted

Behaviour:
- Reset, asynchronous: state=IDLE, counter=0, all control outputs, Done and IllegalOp = 0. InstrReady=1 once reset is released.
- All control outputs are registered and decoded from the state/op registers. No combinational path exists from Op to the ALU controls.
- Accept occurs at the rising edge where InstrValid & InstrReady. The first control cycle is the next cycle. ACC updates at the edge ending each WE cycle.
- Opcodes; unlisted select lines are 0:
  - 0 NOP: no WE. Done in the cycle after accept.
  - 1 LDI: WE, SelImm. ACC=Imm.
  - 2 LDR: WE, SelRegData. ACC=Reg.
  - 3 LDS: go to WAIT_SW until SwStrobe is sampled 1. Next cycle: WE, SelSW, giving ACC=SW.
  - 4 ADDI: WE, UseACC, SelImm.
  - 5 ADDR: WE, UseACC, SelRegData.
  - 6 MULI: WE, UseACC, UseMul. ACC=ACC*Imm.
  - 7 MACR: WE, UseACC, UseMul, SelRegData. ACC=(ACC+Reg)*Imm.
  - 8 MULADD, two WE cycles:
    - step 1: UseACC, UseMul.
    - step 2: UseACC, SelRegData.
    - ACC=ACC*Imm+Reg.
  - 9 POW: Rpt consecutive MULI cycles; the counter loads Rpt and decrements per WE. Rpt=0 means no WE, Done in the cycle after accept.
  - 10-15: illegal. IllegalOp pulses in the cycle after accept, together with Done; no WE.
- States:
  - IDLE -> EXEC (single-cycle ops, NOP, illegal) / WAIT_SW (LDS) / STEP1 (MULADD) / REPEAT (POW, Rpt>0).
  - EXEC -> IDLE.
  - WAIT_SW -> EXEC on SwStrobe. EXEC then drives SelSW.
  - STEP1 -> EXEC; EXEC drives the MULADD step 2.
  - REPEAT self-loops while counter>1, then -> IDLE after the cycle in which counter==1.
- Throughput: single-cycle ops take 2 cycles per instruction (accept + execute); InstrReady is low during execute. POW with Rpt=N is busy for N cycles.
- Arithmetic is 8-bit two's complement, wrap-around, as done by the ALU. The sequencer does no arithmetic on data.
- SwStrobe held high in IDLE has no effect. SwStrobe is sampled only in WAIT_SW. WAIT_SW has no timeout.
- InstrValid while Busy is ignored, with no side effects. Upstream must hold Op/Imm/Reg stable until Done.
- Reset mid-operation aborts immediately: WE drops asynchronously, ACC is reset by the ALU, and no Done is produced.

Test Plan:
- Reset, then LDI Imm=5 followed by ADDI Imm=3 -> WE high exactly 1 cycle per instruction; ACC=8; Done pulses twice; InstrReady low only in each execute cycle.
- ACC=3, MULADD Imm=4 Reg=5 -> WE high 2 consecutive cycles with UseMul=1 then SelRegData=1; ACC=12 then 17; single Done on the second cycle.
- ACC=1, POW Imm=2 Rpt=3 -> WE high 3 cycles; ACC 2,4,8; Done on the 3rd. POW Rpt=0 -> no WE, Done in the cycle after accept, ACC unchanged.
- LDS, with SwStrobe raised 4 cycles after accept and SW=0x2A -> Busy for 5+ cycles; WE/SelSW in the cycle after the strobe; ACC=0x2A; a second InstrValid during the wait is ignored.
- ACC=0x7F, ADDI Imm=1 -> ACC=0x80 (wrap). Op=15 -> IllegalOp and Done pulse once, WE stays 0, ACC unchanged.
- POW Imm=2 Rpt=7, with nReset asserted mid-second-WE -> all outputs 0 immediately, ACC=0, state IDLE, no Done; a new LDI 9 after release completes normally with ACC=9.

Source files
------------

// File: rtl/alu_sequencer.sv
// -----------------------------------------------------------------------------
// alu_sequencer
//
// Sequences the picoMips accumulator ALU. One macro-instruction is accepted at
// a time over a valid/ready handshake. The sequencer then drives the ALU
// control lines for one or more cycles, including multi-cycle operations:
// multiply-then-add (MULADD), repeated multiply (POW) and wait-for-switch load
// (LDS). The ALU's Imm and RegData operands come from upstream and stay stable
// while Busy. The sequencer itself does no arithmetic on data.
//
// Ports:
//   Clock       system clock, rising edge
//   nReset      asynchronous active-low reset
//   InstrValid  upstream has an instruction
//   InstrReady  sequencer can accept (high only in IDLE)
//   Op          macro opcode, sampled on accept
//   Rpt         POW repeat count, sampled on accept
//   SwStrobe    switch value valid, sampled only while waiting for LDS
//   WE          ALU accumulator write enable
//   SelSW       select switches as the ALU operand
//   SelImm      select immediate as the ALU operand
//   SelRegData  select register data as the ALU operand
//   UseMul      ALU multiplies by Imm
//   UseACC      ALU adds the ACC term
//   Busy        instruction in progress
//   Done        one-cycle pulse in the final cycle of an instruction
//   IllegalOp   one-cycle pulse when an undefined opcode was accepted
// -----------------------------------------------------------------------------
module alu_sequencer #(
    parameter int RPT_W = 3,
    parameter int OP_W  = 4
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             InstrValid,
    output logic             InstrReady,
    input  logic [OP_W-1:0]  Op,
    input  logic [RPT_W-1:0] Rpt,
    input  logic             SwStrobe,
    output logic             WE,
    output logic             SelSW,
    output logic             SelImm,
    output logic             SelRegData,
    output logic             UseMul,
    output logic             UseACC,
    output logic             Busy,
    output logic             Done,
    output logic             IllegalOp
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXEC,
        S_WAIT_SW,
        S_STEP1,
        S_REPEAT
    } state_t;

    typedef struct packed {
        logic we;
        logic sel_sw;
        logic sel_imm;
        logic sel_reg;
        logic use_mul;
        logic use_acc;
        logic done;
        logic illegal;
    } ctrl_t;

    localparam logic [OP_W-1:0] OP_NOP    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_LDI    = OP_W'(1);
    localparam logic [OP_W-1:0] OP_LDR    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_LDS    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_ADDI   = OP_W'(4);
    localparam logic [OP_W-1:0] OP_ADDR   = OP_W'(5);
    localparam logic [OP_W-1:0] OP_MULI   = OP_W'(6);
    localparam logic [OP_W-1:0] OP_MACR   = OP_W'(7);
    localparam logic [OP_W-1:0] OP_MULADD = OP_W'(8);
    localparam logic [OP_W-1:0] OP_POW    = OP_W'(9);

    state_t           state_q, state_d;
    logic [OP_W-1:0]  op_q, op_d;
    logic [RPT_W-1:0] cnt_q, cnt_d;
    ctrl_t            ctrl_q, ctrl_d;

    // Control word for a cycle spent in state st. EXEC is shared by all
    // single-cycle ops, the final LDS write and MULADD step 2, so op decides.
    function automatic ctrl_t decode(input state_t st, input logic [OP_W-1:0] op,
                                     input logic last);
        ctrl_t c;
        c = '0;
        case (st)
            S_EXEC: begin
                c.done = 1'b1;
                case (op)
                    OP_NOP, OP_POW: ;  // POW only lands here when Rpt was 0
                    OP_LDI:    begin c.we = 1'b1; c.sel_imm = 1'b1; end
                    OP_LDR:    begin c.we = 1'b1; c.sel_reg = 1'b1; end
                    OP_LDS:    begin c.we = 1'b1; c.sel_sw  = 1'b1; end
                    OP_ADDI:   begin c.we = 1'b1; c.use_acc = 1'b1; c.sel_imm = 1'b1; end
                    OP_ADDR:   begin c.we = 1'b1; c.use_acc = 1'b1; c.sel_reg = 1'b1; end
                    OP_MULI:   begin c.we = 1'b1; c.use_acc = 1'b1; c.use_mul = 1'b1; end
                    OP_MACR:   begin
                        c.we = 1'b1; c.use_acc = 1'b1; c.use_mul = 1'b1; c.sel_reg = 1'b1;
                    end
                    OP_MULADD: begin c.we = 1'b1; c.use_acc = 1'b1; c.sel_reg = 1'b1; end
                    default:   c.illegal = 1'b1;
                endcase
            end
            S_STEP1:  begin c.we = 1'b1; c.use_acc = 1'b1; c.use_mul = 1'b1; end
            S_REPEAT: begin
                c.we = 1'b1; c.use_acc = 1'b1; c.use_mul = 1'b1; c.done = last;
            end
            default: ;
        endcase
        return c;
    endfunction

    // NOTE: every variable assigned here gets a default first so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (InstrValid) begin
                    op_d = Op;
                    case (Op)
                        OP_LDS:    state_d = S_WAIT_SW;
                        OP_MULADD: state_d = S_STEP1;
                        OP_POW: begin
                            if (Rpt != '0) begin
                                state_d = S_REPEAT;
                                cnt_d   = Rpt;
                            end else begin
                                state_d = S_EXEC;
                            end
                        end
                        default:   state_d = S_EXEC;
                    endcase
                end
            end
            S_EXEC:    state_d = S_IDLE;
            S_WAIT_SW: if (SwStrobe) state_d = S_EXEC;
            S_STEP1:   state_d = S_EXEC;
            S_REPEAT: begin
                // The counter holds the writes still to do, including this one.
                cnt_d = cnt_q - RPT_W'(1);
                if (cnt_q <= RPT_W'(1)) state_d = S_IDLE;
            end
            default:   state_d = S_IDLE;
        endcase
        // Controls are decoded from the next state and registered, so Op never
        // reaches the ALU lines combinationally.
        ctrl_d = decode(state_d, op_d, cnt_d == RPT_W'(1));
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the values from before the edge, independent of statement order.
    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign InstrReady = (state_q == S_IDLE);
    assign Busy       = (state_q != S_IDLE);
    assign WE         = ctrl_q.we;
    assign SelSW      = ctrl_q.sel_sw;
    assign SelImm     = ctrl_q.sel_imm;
    assign SelRegData = ctrl_q.sel_reg;
    assign UseMul     = ctrl_q.use_mul;
    assign UseACC     = ctrl_q.use_acc;
    assign Done       = ctrl_q.done;
    assign IllegalOp  = ctrl_q.illegal;

endmodule
